// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP
    } mdu_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic [31:0] DIVIDE_BY_ZERO_LO = 32'hFFFF_FFFF;

    localparam int DEFAULT_ITERATIONS = 32;

endpackage

// File: rtl/hi_lo_multiply_divide_unit_shift_core.sv
// Shared 2W-bit accumulator with one shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle.
module mdu_shift_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic [2*W-1:0] load_acc_i,
    input  logic [W-1:0]   load_op_i,
    input  logic           step_i,
    input  logic           div_mode_i,
    output logic [2*W-1:0] acc_o
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   op_q, op_d;
    logic [W:0]     add_sum;
    logic [W:0]     trial;

    // Multiply: upper half accumulates, lower half shifts the multiplier out.
    // Divide: upper half is the partial remainder, lower half collects quotient.
    always_comb begin
        add_sum = {1'b0, acc_q[2*W-1:W]}
                + (acc_q[0] ? {1'b0, op_q} : '0);
        trial   = acc_q[2*W-1:W-1] - {1'b0, op_q};
        acc_d   = acc_q;
        op_d    = op_q;
        if (load_i) begin
            acc_d = load_acc_i;
            op_d  = load_op_i;
        end else if (step_i) begin
            if (div_mode_i) begin
                acc_d = trial[W]
                      ? {acc_q[2*W-2:0], 1'b0}
                      : {trial[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_d = {add_sum, acc_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            op_q  <= '0;
        end else begin
            acc_q <= acc_d;
            op_q  <= op_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/hi_lo_multiply_divide_unit.sv
// Execute-stage MDU: FSM, sign handling and architectural HI/LO.
// MDU_SINGLE_CYCLE_MULTIPLY_EN: combinational MULT/MULTU; divide unchanged.
module hi_lo_multiply_divide_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = DEFAULT_ITERATIONS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            ALU_function_execute,
    input  logic                  using_HI_LO_execute,
    input  logic [DATA_WIDTH-1:0] src_A_execute,
    input  logic [DATA_WIDTH-1:0] src_B_execute,
    output logic [DATA_WIDTH-1:0] HI_out,
    output logic [DATA_WIDTH-1:0] LO_out,
    output logic                  busy,
    output logic                  stall_mdu,
    output logic                  done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(ITERATIONS + 1);

    mdu_state_e     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           sign_q, sign_d;
    logic           rsign_q, rsign_d;
    logic           div_q, div_d;
    logic           mul_done_q, mul_done_d;

    logic           core_load;
    logic           core_step;
    logic [2*W-1:0] core_load_acc;
    logic [W-1:0]   core_load_op;
    logic [2*W-1:0] core_acc;

    logic           op_signed;
    logic           a_neg, b_neg;
    logic [W-1:0]   abs_a, abs_b;
    logic [W-1:0]   rem_fix, quo_fix;
    logic [2*W-1:0] result;

    always_comb begin
        op_signed = (ALU_function_execute == FUNCT_MULT)
                 || (ALU_function_execute == FUNCT_DIV);
        a_neg = op_signed && src_A_execute[W-1];
        b_neg = op_signed && src_B_execute[W-1];
        abs_a = a_neg ? -src_A_execute : src_A_execute;
        abs_b = b_neg ? -src_B_execute : src_B_execute;
    end

`ifdef MDU_SINGLE_CYCLE_MULTIPLY_EN
    logic [2*W-1:0] ext_a, ext_b, full_prod;

    assign ext_a = op_signed
                 ? {{W{src_A_execute[W-1]}}, src_A_execute}
                 : {{W{1'b0}}, src_A_execute};
    assign ext_b = op_signed
                 ? {{W{src_B_execute[W-1]}}, src_B_execute}
                 : {{W{1'b0}}, src_B_execute};
    assign full_prod = ext_a * ext_b;
`endif

    // Divide-by-zero loads its final HI/LO with both signs clear,
    // so FIXUP passes it through unchanged.
    always_comb begin
        rem_fix = rsign_q ? -core_acc[2*W-1:W] : core_acc[2*W-1:W];
        quo_fix = sign_q ? -core_acc[W-1:0] : core_acc[W-1:0];
        if (div_q) begin
            result = {rem_fix, quo_fix};
        end else if (sign_q) begin
            result = -core_acc;
        end else begin
            result = core_acc;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        sign_d        = sign_q;
        rsign_d       = rsign_q;
        div_d         = div_q;
        mul_done_d    = 1'b0;
        core_load     = 1'b0;
        core_step     = 1'b0;
        core_load_acc = '0;
        core_load_op  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (using_HI_LO_execute) begin
                    unique case (ALU_function_execute)
                        FUNCT_MTHI: hi_d = src_A_execute;
                        FUNCT_MTLO: lo_d = src_A_execute;
                        FUNCT_MFHI, FUNCT_MFLO: ;
                        FUNCT_MULT, FUNCT_MULTU: begin
`ifdef MDU_SINGLE_CYCLE_MULTIPLY_EN
                            {hi_d, lo_d} = full_prod;
                            mul_done_d   = 1'b1;
`else
                            core_load     = 1'b1;
                            core_load_acc = {{W{1'b0}}, abs_b};
                            core_load_op  = abs_a;
                            sign_d        = a_neg ^ b_neg;
                            rsign_d       = 1'b0;
                            div_d         = 1'b0;
                            count_d       = '0;
                            state_d       = S_MUL;
`endif
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            core_load = 1'b1;
                            div_d     = 1'b1;
                            count_d   = '0;
                            if (src_B_execute == '0) begin
                                core_load_acc = {src_A_execute,
                                                 W'(DIVIDE_BY_ZERO_LO)};
                                sign_d        = 1'b0;
                                rsign_d       = 1'b0;
                                state_d       = S_FIXUP;
                            end else begin
                                core_load_acc = {{W{1'b0}}, abs_a};
                                core_load_op  = abs_b;
                                sign_d        = a_neg ^ b_neg;
                                rsign_d       = a_neg;
                                state_d       = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (count_q == CW'(ITERATIONS)) begin
                    state_d = S_FIXUP;
                end else begin
                    core_step = 1'b1;
                    count_d   = count_q + CW'(1);
                end
            end
            S_FIXUP: begin
                {hi_d, lo_d} = result;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            sign_q     <= 1'b0;
            rsign_q    <= 1'b0;
            div_q      <= 1'b0;
            mul_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            sign_q     <= sign_d;
            rsign_q    <= rsign_d;
            div_q      <= div_d;
            mul_done_q <= mul_done_d;
        end
    end

    mdu_shift_core #(
        .W (W)
    ) u_core (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (core_load),
        .load_acc_i (core_load_acc),
        .load_op_i  (core_load_op),
        .step_i     (core_step),
        .div_mode_i (state_q == S_DIV),
        .acc_o      (core_acc)
    );

    assign HI_out    = hi_q;
    assign LO_out    = lo_q;
    assign busy      = (state_q != S_IDLE);
    assign stall_mdu = busy && using_HI_LO_execute;
    assign done      = (state_q == S_FIXUP) || mul_done_q;

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Scoreboard bench for hi_lo_multiply_divide_unit (iterative build).
module tb_hi_lo_multiply_divide_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam int LONG_LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  funct = '0;
    logic        using_hl = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, stall_o, done_o;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          total = 0;
    int          bad = 0;

    hi_lo_multiply_divide_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .ALU_function_execute (funct),
        .using_HI_LO_execute  (using_hl),
        .src_A_execute        (a),
        .src_B_execute        (b),
        .HI_out               (hi_o),
        .LO_out               (lo_o),
        .busy                 (busy_o),
        .stall_mdu            (stall_o),
        .done                 (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: architectural result from plain 64-bit arithmetic.
    task automatic model(input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y);
        longint      sx, sy, p;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            F_MTHI: m_hi = x;
            F_MTLO: m_lo = x;
            F_MULT: begin
                p = sx * sy;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_MULTU: begin
                u = {32'd0, x} * {32'd0, y};
                m_hi = u[63:32];
                m_lo = u[31:0];
            end
            F_DIV, F_DIVU: begin
                if (y == 32'd0) begin
                    m_hi = x;
                    m_lo = 32'hFFFF_FFFF;
                end else if (f == F_DIV) begin
                    p = sx / sy;
                    m_lo = p[31:0];
                    p = sx % sy;
                    m_hi = p[31:0];
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y);
        int waited;
        waited = 0;
        @(negedge clk);
        funct = f;
        a = x;
        b = y;
        using_hl = 1'b1;
        #1;
        while (stall_o === 1'b1 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (stall_o !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: stall=%b required 0", stall_o);
        end else begin
            model(f, x, y);
            if (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                          F_MULT, F_MULTU, F_DIV, F_DIVU})
                sb.push_back('{hi: m_hi, lo: m_lo});
        end
        @(posedge clk);
        #1;
        using_hl = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: independent cycle timing model plus scoreboard pops.
    initial begin : monitor
        int   left;
        logic acc_long, acc_now, dz, done_s;
        exp_t e;
        left = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                left = 0;
                continue;
            end
            check("busy", 32'(busy_o), 32'(left > 0));
            check("done", 32'(done_o), 32'(left == 1));
            check("stall_mdu", 32'(stall_o), 32'(using_hl && left > 0));
            acc_long = using_hl && !stall_o
                    && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
            acc_now  = using_hl && !stall_o
                    && (funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
            dz       = (funct inside {F_DIV, F_DIVU}) && (b == 32'd0);
            done_s   = done_o;
            @(posedge clk);
            #1;
            if (left > 0) left--;
            if (acc_long) left = dz ? 1 : LONG_LAT;
            if (done_s || acc_now) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: result with no expected entry");
                end else begin
                    e = sb.pop_front();
                    check("HI", hi_o, e.hi);
                    check("LO", lo_o, e.lo);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [5:0] fl [8];
        fl = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO,
               F_MULT, F_MULTU, F_DIV, F_DIVU};
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_HI", hi_o, 32'd0);
        check("rst_LO", lo_o, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(F_MULT, 32'hFFFF_FFF9, 32'd3);
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(F_DIVU, 32'd100, 32'd7);
        issue(F_DIVU, 32'h1234, 32'd0);
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(F_MFHI, 32'd0, 32'd0);

        issue(F_DIV, 32'd1000, 32'd7);
        repeat (2) @(negedge clk);
        issue(F_MFLO, 32'd0, 32'd0);
        issue(F_DIVU, 32'd55, 32'd5);
        issue(F_MTHI, 32'hCAFE_BABE, 32'd0);
        issue(F_MFHI, 32'd0, 32'd0);
        issue(6'h20, 32'd1, 32'd2);
        issue(F_MTLO, 32'h1357_9BDF, 32'd0);
        issue(F_MFLO, 32'd0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            issue(fl[$urandom_range(0, 7)], rnd_operand(), rnd_operand());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        issue(F_DIV, 32'hDEAD_BEEF, 32'd5);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_HI", hi_o, 32'd0);
        check("midrst_LO", lo_o, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(F_MULTU, 32'd2, 32'd3);
        issue(F_MFLO, 32'd0, 32'd0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
